pwm_ramp_ctrl: RTL and testbench

Setpoint sequencer for the fractional PWM generator. It accepts period/duty commands over a valid/ready handshake and applies the new period atomically at a PWM period boundary. It then slews the fixed-point duty toward the target by at most a programmed step per PWM period, and drives the PWM's `No`, `N` and fractional inputs. It sits between the host register interface and the PWM datapath.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_ramp_step.sv | 29 ++
 rtl/pwm_ramp_ctrl.sv | 149 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM setpoint sequencer.
package pwm_pkg;

  localparam int          PWM_FSZE   = 3;
  localparam logic [16:0] PWM_RST_NO = 17'd999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RAMP  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_ramp_step.sv
// Combinational ramp step: move cur toward tgt by at most step (step 0 jumps).
module pwm_ramp_step #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] next,
  output logic             at_tgt
);

  logic             w_up;
  logic [WIDTH-1:0] w_diff;

  // Distance to target, then a bounded move; cur+step cannot pass tgt so it never overflows
  always_comb begin
    w_up   = (tgt >= cur);
    w_diff = w_up ? (tgt - cur) : (cur - tgt);
    if ((step == {WIDTH{1'b0}}) || (w_diff <= step)) begin
      next = tgt;
    end else if (w_up) begin
      next = cur + step;
    end else begin
      next = cur - step;
    end
    at_tgt = (next == tgt);
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Setpoint sequencer: accepts period/duty commands, swaps the period at a PWM
// boundary and slews the fixed-point duty toward the target once per period.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int               WIDTH  = 17,
  parameter int               FSZE   = PWM_FSZE,
  parameter logic [WIDTH-1:0] RST_NO = PWM_RST_NO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_no,
  input  logic [WIDTH-1:0] cmd_duty,
  input  logic [WIDTH-1:0] cmd_step,
  input  logic             abort,
  input  logic             period_sync,
  output logic [WIDTH-1:0] pwm_no,
  output logic [WIDTH-1:0] pwm_n,
  output logic [WIDTH-1:0] pwm_mf,
  output logic             busy,
  output logic             done
);

  localparam int XW = WIDTH + FSZE;

  state_t           r_state;
  logic [WIDTH-1:0] r_no_nxt;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] r_pwm_no;
  logic [WIDTH-1:0] r_duty;
  logic             r_done;

  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_load_no;
  logic             w_apply;
  logic             w_done_nxt;
  logic [XW-1:0]    w_no_sh;
  logic [XW-1:0]    w_duty_ext;
  logic [XW-1:0]    w_clamp;
  logic [WIDTH-1:0] w_tgt_in;
  logic [WIDTH-1:0] w_step_next;
  logic             w_step_at_tgt;

  // Target may not exceed the period expressed in duty units; widen first so the shift cannot wrap
  always_comb begin
    w_no_sh    = {{FSZE{1'b0}}, cmd_no} << FSZE;
    w_duty_ext = {{FSZE{1'b0}}, cmd_duty};
    w_clamp    = (w_duty_ext < w_no_sh) ? w_duty_ext : w_no_sh;
    if (|w_clamp[XW-1:WIDTH]) begin
      w_tgt_in = {WIDTH{1'b1}};
    end else begin
      w_tgt_in = w_clamp[WIDTH-1:0];
    end
  end

  pwm_ramp_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur    (r_duty),
    .tgt    (r_tgt),
    .step   (r_step),
    .next   (w_step_next),
    .at_tgt (w_step_at_tgt)
  );

  // Next-state and update enables; abort takes priority over a coincident sync
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load_no   = 1'b0;
    w_apply     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (period_sync) begin
          w_load_no   = 1'b1;
          w_apply     = 1'b1;
          w_done_nxt  = w_step_at_tgt;
          w_state_nxt = w_step_at_tgt ? ST_IDLE : ST_RAMP;
        end else begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_RAMP: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (period_sync) begin
          w_apply     = 1'b1;
          w_done_nxt  = w_step_at_tgt;
          w_state_nxt = w_step_at_tgt ? ST_IDLE : ST_RAMP;
        end else begin
          w_state_nxt = ST_RAMP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, latched command and PWM-facing output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_no_nxt <= {WIDTH{1'b0}};
      r_tgt    <= {WIDTH{1'b0}};
      r_step   <= {WIDTH{1'b0}};
      r_pwm_no <= RST_NO;
      r_duty   <= {WIDTH{1'b0}};
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_no_nxt <= cmd_no;
        r_tgt    <= w_tgt_in;
        r_step   <= cmd_step;
      end
      if (w_load_no) begin
        r_pwm_no <= r_no_nxt;
      end
      if (w_apply) begin
        r_duty <= w_step_next;
      end
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign pwm_no    = r_pwm_no;
  assign pwm_n     = r_duty >> FSZE;
  assign pwm_mf    = {{(WIDTH-FSZE){1'b0}}, r_duty[FSZE-1:0]};

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed scoreboard bench for pwm_ramp_ctrl: expected outputs are queued per
// driven cycle and compared after the sampling edge.
module tb_pwm_ramp_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [16:0] cmd_no;
  logic [16:0] cmd_duty;
  logic [16:0] cmd_step;
  logic        abort;
  logic        period_sync;
  logic [16:0] pwm_no;
  logic [16:0] pwm_n;
  logic [16:0] pwm_mf;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [16:0] no;
    logic [16:0] duty;
    logic        dn;
    logic        rdy;
  } exp_t;

  exp_t sb[$];

  pwm_ramp_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_no      (cmd_no),
    .cmd_duty    (cmd_duty),
    .cmd_step    (cmd_step),
    .abort       (abort),
    .period_sync (period_sync),
    .pwm_no      (pwm_no),
    .pwm_n       (pwm_n),
    .pwm_mf      (pwm_mf),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [16:0] no, input logic [16:0] duty,
                      input logic dn, input logic rdy);
    exp_t e;
    e.tag = tag; e.no = no; e.duty = duty; e.dn = dn; e.rdy = rdy;
    sb.push_back(e);
  endtask

  task automatic check_one();
    exp_t e;
    logic [16:0] en;
    logic [16:0] emf;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 entries required>=1");
    end
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      en  = e.duty >> 3;
      emf = e.duty & 17'd7;
      checks++;
      assert (pwm_no === e.no) else begin
        errors++; $error("FAIL %s pwm_no observed=%0d expected=%0d", e.tag, pwm_no, e.no);
      end
      checks++;
      assert (pwm_n === en) else begin
        errors++; $error("FAIL %s pwm_n observed=%0d expected=%0d", e.tag, pwm_n, en);
      end
      checks++;
      assert (pwm_mf === emf) else begin
        errors++; $error("FAIL %s pwm_mf observed=%0d expected=%0d", e.tag, pwm_mf, emf);
      end
      checks++;
      assert (done === e.dn) else begin
        errors++; $error("FAIL %s done observed=%0b expected=%0b", e.tag, done, e.dn);
      end
      checks++;
      assert (cmd_ready === e.rdy) else begin
        errors++; $error("FAIL %s cmd_ready observed=%0b expected=%0b", e.tag, cmd_ready, e.rdy);
      end
      checks++;
      assert (busy === ~e.rdy) else begin
        errors++; $error("FAIL %s busy observed=%0b expected=%0b", e.tag, busy, ~e.rdy);
      end
    end
  endtask

  task automatic set_cmd(input logic [16:0] no, input logic [16:0] duty, input logic [16:0] step);
    cmd_no = no; cmd_duty = duty; cmd_step = step;
  endtask

  // Drive one cycle of inputs (called at a falling edge), sample after the rising edge
  task automatic tick(input logic v, input logic s, input logic a);
    cmd_valid = v; period_sync = s; abort = a;
    @(posedge clk);
    #1;
    check_one();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; period_sync = 1'b0;
    set_cmd(17'd0, 17'd0, 17'd0);
    #1;
    push("reset", 17'd999, 17'd0, 1'b0, 1'b1);
    check_one();
    @(negedge clk);
    rst = 1'b0;

    // Ramp up 0 -> 40 by 16
    set_cmd(17'd999, 17'd40, 17'd16);
    push("up_acc", 17'd999, 17'd0, 1'b0, 1'b0);   tick(1'b1, 1'b0, 1'b0);
    push("up_s1", 17'd999, 17'd16, 1'b0, 1'b0);   tick(1'b0, 1'b1, 1'b0);
    push("up_hold", 17'd999, 17'd16, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
    push("up_s2", 17'd999, 17'd32, 1'b0, 1'b0);   tick(1'b0, 1'b1, 1'b0);
    push("up_s3", 17'd999, 17'd40, 1'b1, 1'b1);   tick(1'b0, 1'b1, 1'b0);
    push("up_idle", 17'd999, 17'd40, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b0);

    // Clamp: No=10 limits target to 80
    set_cmd(17'd10, 17'd1000, 17'd0);
    push("clamp_acc", 17'd999, 17'd40, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
    push("clamp_s1", 17'd10, 17'd80, 1'b1, 1'b1);   tick(1'b0, 1'b1, 1'b0);

    // Ramp down 80 -> 5 by 30
    set_cmd(17'd10, 17'd5, 17'd30);
    push("dn_acc", 17'd10, 17'd80, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
    push("dn_s1", 17'd10, 17'd50, 1'b0, 1'b0);  tick(1'b0, 1'b1, 1'b0);
    push("dn_s2", 17'd10, 17'd20, 1'b0, 1'b0);  tick(1'b0, 1'b1, 1'b0);
    push("dn_s3", 17'd10, 17'd5, 1'b1, 1'b1);   tick(1'b0, 1'b1, 1'b0);

    // Abort in RAMP at duty 32 together with a sync
    set_cmd(17'd10, 17'd200, 17'd27);
    push("ab_acc", 17'd10, 17'd5, 1'b0, 1'b0);   tick(1'b1, 1'b0, 1'b0);
    push("ab_s1", 17'd10, 17'd32, 1'b0, 1'b0);   tick(1'b0, 1'b1, 1'b0);
    push("ab_hit", 17'd10, 17'd32, 1'b0, 1'b1);  tick(1'b0, 1'b1, 1'b1);
    push("ab_after", 17'd10, 17'd32, 1'b0, 1'b1); tick(1'b0, 1'b1, 1'b0);

    // Abort in ARMED discards the latched period
    set_cmd(17'd50, 17'd8, 17'd0);
    push("aba_acc", 17'd10, 17'd32, 1'b0, 1'b0);  tick(1'b1, 1'b0, 1'b0);
    push("aba_hit", 17'd10, 17'd32, 1'b0, 1'b1);  tick(1'b0, 1'b0, 1'b1);
    push("aba_sync", 17'd10, 17'd32, 1'b0, 1'b1); tick(1'b0, 1'b1, 1'b0);

    // Valid held high: second command only accepted after done; sync in accept cycle ignored
    set_cmd(17'd999, 17'd0, 17'd16);
    push("hs_acc1", 17'd10, 17'd32, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
    set_cmd(17'd999, 17'd8, 17'd0);
    push("hs_s1", 17'd999, 17'd16, 1'b0, 1'b0);  tick(1'b1, 1'b1, 1'b0);
    push("hs_s2", 17'd999, 17'd0, 1'b1, 1'b1);   tick(1'b1, 1'b1, 1'b0);
    push("hs_acc2", 17'd999, 17'd0, 1'b0, 1'b0); tick(1'b1, 1'b1, 1'b0);
    push("hs_jump", 17'd999, 17'd8, 1'b1, 1'b1); tick(1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a ramp
    set_cmd(17'd20, 17'd160, 17'd8);
    push("rr_acc", 17'd999, 17'd8, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
    push("rr_s1", 17'd20, 17'd16, 1'b0, 1'b0);  tick(1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    push("rr_async", 17'd999, 17'd0, 1'b0, 1'b1);
    check_one();
    @(negedge clk);
    rst = 1'b0;

    // Jump after reset: 4004 -> n=500, mf=4
    set_cmd(17'd999, 17'd4004, 17'd0);
    push("jmp_acc", 17'd999, 17'd0, 1'b0, 1'b0);     tick(1'b1, 1'b0, 1'b0);
    push("jmp_s1", 17'd999, 17'd4004, 1'b1, 1'b1);   tick(1'b0, 1'b1, 1'b0);
    push("jmp_idle", 17'd999, 17'd4004, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d entries required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
